// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_pkg
//  Purpose  : Shared defaults, state encoding and output activation helper
//             for the MLP layer engine datapath.
//  Contents : MLP_* width defaults, state_t (IDLE/ACCUM), sat_relu()
//  Revision : 1.0 - initial release
// ============================================================================
package mlp_pkg;

   localparam int MLP_DATA_W    = 16;   // Q8.8 neuron / weight width
   localparam int MLP_FRAC_BITS = 8;
   localparam int MLP_ACC_W     = 44;   // 2*DATA_W + 12 guard bits
   localparam int MLP_NEURON_AW = 12;
   localparam int MLP_WEIGHT_AW = 16;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // Convert a Q.(2*FRAC) accumulator into a Q8.8 result: arithmetic shift
   // (floor toward -inf), saturate to the signed DATA_W range, optional ReLU.
   function automatic logic [MLP_DATA_W-1:0] sat_relu(
      input logic signed [MLP_ACC_W-1:0] acc,
      input int                          frac_bits,
      input logic                        relu_en
   );
      logic signed [MLP_ACC_W-1:0] sh;
      logic signed [MLP_ACC_W-1:0] hi;
      logic signed [MLP_ACC_W-1:0] lo;
      logic        [MLP_DATA_W-1:0] res;
      hi = {{(MLP_ACC_W-MLP_DATA_W+1){1'b0}}, {(MLP_DATA_W-1){1'b1}}};
      lo = {{(MLP_ACC_W-MLP_DATA_W+1){1'b1}}, {(MLP_DATA_W-1){1'b0}}};
      sh = acc >>> frac_bits;
      if (sh > hi)
         res = {1'b0, {(MLP_DATA_W-1){1'b1}}};
      else if (sh < lo)
         res = {1'b1, {(MLP_DATA_W-1){1'b0}}};
      else
         res = sh[MLP_DATA_W-1:0];
      if (relu_en && res[MLP_DATA_W-1])
         res = '0;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_mac_pipe
//  Purpose  : Pipelined signed multiply-accumulate with first/last/address
//             sideband travelling alongside each term.
//  Ports    : issue_i/first_i/last_i/addr_i  term issued this cycle
//             neuron_data_i/weight_data_i     RAM data, one cycle after issue
//             acc_o        accumulator (valid with done_o)
//             done_o       last term of a neuron has just been accumulated
//             done_addr_o  destination address of that neuron
//             busy_o       any term still in the pipe
//  Revision : 1.0 - initial release
// ============================================================================
module mlp_mac_pipe
   import mlp_pkg::*;
#(
   parameter int DATA_W    = MLP_DATA_W,
   parameter int ACC_W     = MLP_ACC_W,
   parameter int NEURON_AW = MLP_NEURON_AW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        issue_i,
   input  logic                        first_i,
   input  logic                        last_i,
   input  logic        [NEURON_AW-1:0] addr_i,
   input  logic signed [DATA_W-1:0]    neuron_data_i,
   input  logic signed [DATA_W-1:0]    weight_data_i,
   output logic signed [ACC_W-1:0]     acc_o,
   output logic                        done_o,
   output logic        [NEURON_AW-1:0] done_addr_o,
   output logic                        busy_o
);

   // Stage 1: sideband aligned with RAM read data
   logic                 v1_q, first1_q, last1_q;
   logic [NEURON_AW-1:0] addr1_q;
   // Stage 2: product register
   logic                 v2_q, first2_q, last2_q;
   logic [NEURON_AW-1:0] addr2_q;
   logic signed [2*DATA_W-1:0] prod_q;
   // Stage 3: accumulator
   logic                 v3_q, last3_q;
   logic [NEURON_AW-1:0] addr3_q;
   logic signed [ACC_W-1:0] acc_q;

   logic signed [ACC_W-1:0] w_prod_ext;
   assign w_prod_ext = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         addr1_q  <= '0;
         v2_q     <= 1'b0;
         first2_q <= 1'b0;
         last2_q  <= 1'b0;
         addr2_q  <= '0;
         prod_q   <= '0;
         v3_q     <= 1'b0;
         last3_q  <= 1'b0;
         addr3_q  <= '0;
         acc_q    <= '0;
      end else begin
         v1_q     <= issue_i;
         first1_q <= first_i;
         last1_q  <= last_i;
         addr1_q  <= addr_i;

         v2_q     <= v1_q;
         first2_q <= first1_q;
         last2_q  <= last1_q;
         addr2_q  <= addr1_q;
         if (v1_q)
            prod_q <= neuron_data_i * weight_data_i;

         v3_q     <= v2_q;
         last3_q  <= last2_q;
         addr3_q  <= addr2_q;
         // A first term reloads, which also discards any abandoned neuron.
         if (v2_q)
            acc_q <= first2_q ? w_prod_ext : acc_q + w_prod_ext;
      end
   end

   assign acc_o       = acc_q;
   assign done_o      = v3_q & last3_q;
   assign done_addr_o = addr3_q;
   assign busy_o      = v1_q | v2_q | v3_q;

endmodule
`default_nettype wire

// File: rtl/neuron_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_datapath
//  Purpose  : Arithmetic end of the MLP layer engine. Issues terms from the
//             control_unit command stream, reads neuron/weight RAMs, runs the
//             Q8.8 MAC and writes each finished neuron back to neuron RAM.
//  Ports    : *_addr_i, reset_mult_acc_i, write_neuron_i  command stream
//             neuron_rd_*/weight_rd_*   RAM read ports (1-cycle latency)
//             neuron_wr_*               registered write-back port
//             busy_o, neurons_written_o, err_orphan_o  status
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_datapath
   import mlp_pkg::*;
#(
   parameter int DATA_W    = MLP_DATA_W,
   parameter int FRAC_BITS = MLP_FRAC_BITS,
   parameter int ACC_W     = MLP_ACC_W,
   parameter int NEURON_AW = MLP_NEURON_AW,
   parameter int WEIGHT_AW = MLP_WEIGHT_AW,
   parameter bit RELU_EN   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NEURON_AW-1:0] input_neuron_addr_i,
   input  logic [WEIGHT_AW-1:0] input_weight_addr_i,
   input  logic [NEURON_AW-1:0] output_neuron_addr_i,
   input  logic                 reset_mult_acc_i,
   input  logic                 write_neuron_i,
   output logic [NEURON_AW-1:0] neuron_rd_addr_o,
   input  logic [DATA_W-1:0]    neuron_rd_data_i,
   output logic [WEIGHT_AW-1:0] weight_rd_addr_o,
   input  logic [DATA_W-1:0]    weight_rd_data_i,
   output logic                 neuron_wr_en_o,
   output logic [NEURON_AW-1:0] neuron_wr_addr_o,
   output logic [DATA_W-1:0]    neuron_wr_data_o,
   output logic                 busy_o,
   output logic [NEURON_AW-1:0] neurons_written_o,
   output logic                 err_orphan_o
);

   state_t state_q, state_d;
   logic   w_issue, w_first, w_last, w_orphan;

   logic signed [ACC_W-1:0] w_acc;
   logic                    w_done;
   logic [NEURON_AW-1:0]    w_done_addr;
   logic                    w_pipe_busy;

   logic                 wr_en_q;
   logic [NEURON_AW-1:0] wr_addr_q;
   logic [DATA_W-1:0]    wr_data_q;
   logic [NEURON_AW-1:0] count_q;
   logic                 err_q;

   assign neuron_rd_addr_o = input_neuron_addr_i;
   assign weight_rd_addr_o = input_weight_addr_i;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (w_issue)
         state_d = write_neuron_i ? ST_IDLE : ST_ACCUM;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_issue  = (state_q == ST_ACCUM) | reset_mult_acc_i;
      w_first  = reset_mult_acc_i;
      w_last   = write_neuron_i & w_issue;
      w_orphan = (state_q == ST_IDLE) & write_neuron_i & ~reset_mult_acc_i;
   end

   mlp_mac_pipe #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .NEURON_AW (NEURON_AW)
   ) u_mac (
      .clk           (clk),
      .rst           (rst),
      .issue_i       (w_issue),
      .first_i       (w_first),
      .last_i        (w_last),
      .addr_i        (output_neuron_addr_i),
      .neuron_data_i (neuron_rd_data_i),
      .weight_data_i (weight_rd_data_i),
      .acc_o         (w_acc),
      .done_o        (w_done),
      .done_addr_o   (w_done_addr),
      .busy_o        (w_pipe_busy)
   );

   // Write-back register and status counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_en_q <= w_done;
         if (w_done) begin
            wr_addr_q <= w_done_addr;
            wr_data_q <= sat_relu(w_acc, FRAC_BITS, RELU_EN);
            count_q   <= count_q + 1'b1;
         end
         if (w_orphan)
            err_q <= 1'b1;
      end
   end

   assign neuron_wr_en_o    = wr_en_q;
   assign neuron_wr_addr_o  = wr_addr_q;
   assign neuron_wr_data_o  = wr_data_q;
   assign neurons_written_o = count_q;
   assign err_orphan_o      = err_q;
   // Includes the strobe cycle so busy drops the cycle after the last write.
   assign busy_o = (state_q == ST_ACCUM) | w_pipe_busy | wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_datapath
//  Purpose  : Directed-vector scoreboard bench; two instances (ReLU on/off)
//             share one command stream, each with its own RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_datapath;

   localparam int DW  = 16;
   localparam int NAW = 12;
   localparam int WAW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NAW-1:0] in_naddr, out_naddr;
   logic [WAW-1:0] in_waddr;
   logic           rma, wn;

   // ReLU instance (r_) and linear instance (n_) outputs
   logic [NAW-1:0] r_nrd_addr, n_nrd_addr, r_wr_addr, n_wr_addr, r_nw, n_nw;
   logic [WAW-1:0] r_wrd_addr, n_wrd_addr;
   logic [DW-1:0]  r_nrd_data, n_nrd_data, r_wrd_data, n_wrd_data, r_wr_data, n_wr_data;
   logic           r_wr_en, n_wr_en, r_busy, n_busy, r_err, n_err;

   neuron_datapath #(.RELU_EN(1'b1)) u_dut_r (
      .clk(clk), .rst(rst),
      .input_neuron_addr_i(in_naddr), .input_weight_addr_i(in_waddr),
      .output_neuron_addr_i(out_naddr), .reset_mult_acc_i(rma), .write_neuron_i(wn),
      .neuron_rd_addr_o(r_nrd_addr), .neuron_rd_data_i(r_nrd_data),
      .weight_rd_addr_o(r_wrd_addr), .weight_rd_data_i(r_wrd_data),
      .neuron_wr_en_o(r_wr_en), .neuron_wr_addr_o(r_wr_addr), .neuron_wr_data_o(r_wr_data),
      .busy_o(r_busy), .neurons_written_o(r_nw), .err_orphan_o(r_err));

   neuron_datapath #(.RELU_EN(1'b0)) u_dut_n (
      .clk(clk), .rst(rst),
      .input_neuron_addr_i(in_naddr), .input_weight_addr_i(in_waddr),
      .output_neuron_addr_i(out_naddr), .reset_mult_acc_i(rma), .write_neuron_i(wn),
      .neuron_rd_addr_o(n_nrd_addr), .neuron_rd_data_i(n_nrd_data),
      .weight_rd_addr_o(n_wrd_addr), .weight_rd_data_i(n_wrd_data),
      .neuron_wr_en_o(n_wr_en), .neuron_wr_addr_o(n_wr_addr), .neuron_wr_data_o(n_wr_data),
      .busy_o(n_busy), .neurons_written_o(n_nw), .err_orphan_o(n_err));

   // Read-only synchronous RAM models, one-cycle latency
   logic [DW-1:0] nram [0:15];
   logic [DW-1:0] wram [0:15];
   initial begin
      for (int i = 0; i < 16; i++) begin
         nram[i] = '0;
         wram[i] = '0;
      end
      nram[0] = 16'h0100;  // 1.0
      nram[1] = 16'h0200;  // 2.0
      nram[2] = 16'hFF00;  // -1.0
      nram[3] = 16'h7F00;  // 127.0
      nram[4] = 16'h8100;  // -127.0
      nram[5] = 16'hFD00;  // -3.0
      nram[7] = 16'hFFFF;  // -1/256
      wram[0] = 16'h0100;  // 1.0
      wram[1] = 16'h0200;  // 2.0
      wram[2] = 16'h0080;  // 0.5
      wram[3] = 16'h7F00;  // 127.0
   end
   always @(posedge clk) begin
      r_nrd_data <= nram[r_nrd_addr[3:0]];
      r_wrd_data <= wram[r_wrd_addr[3:0]];
      n_nrd_data <= nram[n_nrd_addr[3:0]];
      n_wrd_data <= wram[n_wrd_addr[3:0]];
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [NAW-1:0] addr;
      logic [DW-1:0]  data;
      int unsigned    cyc;
   } exp_t;

   exp_t q_r[$];
   exp_t q_n[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   int unsigned cnt_r = 0;
   int unsigned cnt_n = 0;

   // Monitor: pops an expectation for every write strobe
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            cnt_r = 0;
            cnt_n = 0;
         end else begin
            if (r_wr_en) begin
               if (q_r.size() == 0) chk("r_unexpected_write", 32'd1, 32'd0);
               else begin
                  e = q_r.pop_front();
                  cnt_r++;
                  chk("r_wr_addr", 32'(r_wr_addr), 32'(e.addr));
                  chk("r_wr_data", 32'(r_wr_data), 32'(e.data));
                  chk("r_wr_cycle", cyc, e.cyc);
                  chk("r_count", 32'(r_nw), cnt_r);
               end
            end else if (q_r.size() > 0 && q_r[0].cyc < cyc) begin
               chk("r_missed_write", 32'd0, 32'd1);
               void'(q_r.pop_front());
            end
            if (n_wr_en) begin
               if (q_n.size() == 0) chk("n_unexpected_write", 32'd1, 32'd0);
               else begin
                  e = q_n.pop_front();
                  cnt_n++;
                  chk("n_wr_addr", 32'(n_wr_addr), 32'(e.addr));
                  chk("n_wr_data", 32'(n_wr_data), 32'(e.data));
                  chk("n_wr_cycle", cyc, e.cyc);
                  chk("n_count", 32'(n_nw), cnt_n);
               end
            end else if (q_n.size() > 0 && q_n[0].cyc < cyc) begin
               chk("n_missed_write", 32'd0, 32'd1);
               void'(q_n.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic term(input bit f, input bit l, input int na, input int wa, input int oa,
                       input bit exp_w, input logic [DW-1:0] er, input logic [DW-1:0] en);
      exp_t e;
      rma       = f;
      wn        = l;
      in_naddr  = NAW'(na);
      in_waddr  = WAW'(wa);
      out_naddr = NAW'(oa);
      if (exp_w) begin
         e.addr = NAW'(oa);
         e.cyc  = cyc + 4;
         e.data = er;
         q_r.push_back(e);
         e.data = en;
         q_n.push_back(e);
      end
      step();
   endtask

   task automatic idle(input int n);
      rma = 1'b0;
      wn  = 1'b0;
      repeat (n) step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_r_wr_en"},   32'(r_wr_en),   32'd0);
      chk({tag, "_r_wr_addr"}, 32'(r_wr_addr), 32'd0);
      chk({tag, "_r_wr_data"}, 32'(r_wr_data), 32'd0);
      chk({tag, "_r_count"},   32'(r_nw),      32'd0);
      chk({tag, "_r_busy"},    32'(r_busy),    32'd0);
      chk({tag, "_r_err"},     32'(r_err),     32'd0);
      chk({tag, "_n_wr_en"},   32'(n_wr_en),   32'd0);
      chk({tag, "_n_wr_data"}, 32'(n_wr_data), 32'd0);
      chk({tag, "_n_count"},   32'(n_nw),      32'd0);
      chk({tag, "_n_busy"},    32'(n_busy),    32'd0);
   endtask

   initial begin
      rma = 1'b0; wn = 1'b0; in_naddr = '0; in_waddr = '0; out_naddr = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Single-term neuron: 1.0 * 2.0 -> addr 0x005
      term(1, 1, 0, 1, 5, 1, 16'h0200, 16'h0200);
      idle(3);
      @(negedge clk);
      chk("busy_at_strobe", 32'(r_busy), 32'd1);
      step();
      @(negedge clk);
      chk("busy_after_strobe_r", 32'(r_busy), 32'd0);
      chk("busy_after_strobe_n", 32'(n_busy), 32'd0);
      step();
      idle(2);

      // Three terms: 1*1 + 2*0.5 + (-1)*1 = 1.0
      term(1, 0, 0, 0, 6, 0, 16'h0, 16'h0);
      term(0, 0, 1, 2, 6, 0, 16'h0, 16'h0);
      term(0, 1, 2, 0, 6, 1, 16'h0100, 16'h0100);
      idle(6);

      // -3.0: ReLU clamps, linear keeps
      term(1, 1, 5, 0, 7, 1, 16'h0000, 16'hFD00);
      idle(6);

      // Positive saturation: 4 * 127*127
      term(1, 0, 3, 3, 8, 0, 16'h0, 16'h0);
      term(0, 0, 3, 3, 8, 0, 16'h0, 16'h0);
      term(0, 0, 3, 3, 8, 0, 16'h0, 16'h0);
      term(0, 1, 3, 3, 8, 1, 16'h7FFF, 16'h7FFF);
      idle(6);

      // Negative saturation: 4 * -127*127
      term(1, 0, 4, 3, 9, 0, 16'h0, 16'h0);
      term(0, 0, 4, 3, 9, 0, 16'h0, 16'h0);
      term(0, 0, 4, 3, 9, 0, 16'h0, 16'h0);
      term(0, 1, 4, 3, 9, 1, 16'h0000, 16'h8000);
      idle(6);

      // Back-to-back neurons: 2+1 = 3.0 to 0x010, then 1.0 to 0x011
      term(1, 0, 1, 0, 16, 0, 16'h0, 16'h0);
      term(0, 1, 0, 0, 16, 1, 16'h0300, 16'h0300);
      term(1, 1, 0, 0, 17, 1, 16'h0100, 16'h0100);
      idle(6);

      // Restart inside ACCUM drops neuron 0x012; 2*2 = 4.0 to 0x013
      term(1, 0, 0, 0, 18, 0, 16'h0, 16'h0);
      term(1, 1, 1, 1, 19, 1, 16'h0400, 16'h0400);
      idle(6);

      // Floor rounding: -1/256 * 0.5 -> -1/256
      term(1, 1, 7, 2, 20, 1, 16'h0000, 16'hFFFF);
      idle(8);

      chk("queue_r_drained", 32'(q_r.size()), 32'd0);
      chk("queue_n_drained", 32'(q_n.size()), 32'd0);

      // Reset two cycles after a last term: nothing may be written
      term(1, 1, 0, 0, 21, 0, 16'h0, 16'h0);
      idle(1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(8);
      @(negedge clk);
      chk_all_zero("midrst");
      step();

      // Orphan write_neuron in IDLE
      term(0, 1, 3, 3, 22, 0, 16'h0, 16'h0);
      idle(0);
      @(negedge clk);
      chk("orphan_err_r", 32'(r_err), 32'd1);
      chk("orphan_err_n", 32'(n_err), 32'd1);
      chk("orphan_busy", 32'(r_busy), 32'd0);
      step();
      idle(6);
      chk("orphan_count", 32'(r_nw), 32'd0);

      // Bounded drain of any remaining expectations
      for (int i = 0; i < 20 && (q_r.size() != 0 || q_n.size() != 0); i++) step();
      chk("final_queue_r", 32'(q_r.size()), 32'd0);
      chk("final_queue_n", 32'(q_n.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
